// File: rtl/nes_pad_reader_if.sv
// nes_pad_reader_if
// Groups the host-side request/result signals and the three-wire joypad
// link of one NES pad reader.
//   poll_req   host -> reader   start a poll (ignored while busy)
//   busy       reader -> host   poll in progress
//   valid      reader -> host   one-cycle pulse, buttons just updated
//   buttons    reader -> host   8 buttons, 1 = pressed
//   pad_latch  reader -> pad    parallel-load strobe
//   pad_clk    reader -> pad    shift clock, idles high
//   pad_data   pad -> reader    serial button data (asynchronous)
// master = the reader (initiator of the link), slave = host/pad side.
interface nes_pad_reader_if;
  logic       poll_req;
  logic       busy;
  logic       valid;
  logic [7:0] buttons;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;

  modport master (
    input  poll_req, pad_data,
    output busy, valid, buttons, pad_latch, pad_clk
  );

  modport slave (
    output poll_req, pad_data,
    input  busy, valid, buttons, pad_latch, pad_clk
  );
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader
// Polls a 4021-based NES gamepad and presents its eight buttons as an
// active-high parallel word. Each protocol phase lasts 2^CLK_DIV_BITS cycles;
// one poll takes 16 phases.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  nes_pad_reader_if.master (poll_req/busy/valid/buttons host side,
//        pad_latch/pad_clk/pad_data joypad side)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for poll_req; pad_latch low, pad_clk high
// LATCH   | pad_latch high for one phase, pad loads its buttons
// READ_LO | pad_clk low; bit sampled at the end of the phase
// READ_HI | pad_clk high; pad shifts the next bit out
module nes_pad_reader #(
  parameter int   CLK_DIV_BITS = 8,
  parameter logic INVERT_DATA  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  nes_pad_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, LATCH, READ_LO, READ_HI} state_t;

  state_t                  state_q, state_d;
  logic [CLK_DIV_BITS-1:0] clk_div_q, clk_div_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [7:0]              buttons_q, buttons_d;
  logic                    pad_latch_q, pad_latch_d;
  logic                    pad_clk_q, pad_clk_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [1:0]              sync_q;
  logic                    data_s;
  logic                    tick;

  assign data_s = sync_q[1] ^ INVERT_DATA;
  assign tick   = &clk_div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_div_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      buttons_q   <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      clk_div_q   <= clk_div_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      buttons_q   <= buttons_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      sync_q      <= {sync_q[0], bus.pad_data};
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    buttons_d   = buttons_q;
    pad_latch_d = pad_latch_q;
    pad_clk_d   = pad_clk_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    // Phase counter runs only during a poll and restarts every phase.
    if (state_q == IDLE || tick) clk_div_d = '0;
    else                         clk_div_d = clk_div_q + CLK_DIV_BITS'(1);

    case (state_q)
      IDLE: begin
        if (bus.poll_req) begin
          state_d     = LATCH;
          pad_latch_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      LATCH: begin
        if (tick) begin
          state_d     = READ_LO;
          pad_latch_d = 1'b0;
          pad_clk_d   = 1'b0;
          bit_cnt_d   = '0;
        end
      end
      READ_LO: begin
        if (tick) begin
          // A arrives first, so after eight shifts it lands in bit 0.
          shreg_d   = {data_s, shreg_q[7:1]};
          pad_clk_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            buttons_d = {data_s, shreg_q[7:1]};
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d   = READ_HI;
          end
        end
      end
      READ_HI: begin
        if (tick) begin
          pad_clk_d = 1'b0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = READ_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pad_latch = pad_latch_q;
  assign bus.pad_clk   = pad_clk_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.buttons   = buttons_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader
// Two readers with CLK_DIV_BITS=2 (P=4): dut_a with INVERT_DATA=1 against an
// active-low 4021 model, dut_b with INVERT_DATA=0 against an active-high one.
// A poll-timeline model predicts every output each cycle; directed tests pin
// the model with literal expectations.
module tb_nes_pad_reader;
  localparam int CDB  = 2;
  localparam int P    = 1 << CDB;
  localparam int POLL = 16 * P;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nes_pad_reader_if ifa ();
  nes_pad_reader_if ifb ();

  logic       poll_a = 1'b0, poll_b = 1'b0, tie_a = 1'b0;
  logic [7:0] mask_a = 8'h00, mask_b = 8'h00;
  int         idx_a = 0, idx_b = 0;
  int         checks = 0, errors = 0;
  int         va_cnt = 0;
  logic       chk_en = 1'b0;

  assign ifa.poll_req = poll_a;
  assign ifb.poll_req = poll_b;
  // 4021 models: A first, next bit on each pad_clk rise, serial fill after 8.
  assign ifa.pad_data = tie_a ? 1'b1 : ((idx_a < 8) ? ~mask_a[idx_a[2:0]] : 1'b1);
  assign ifb.pad_data = (idx_b < 8) ? mask_b[idx_b[2:0]] : 1'b0;

  always @(posedge ifa.pad_clk or posedge ifa.pad_latch)
    if (ifa.pad_latch) idx_a <= 0; else if (idx_a < 8) idx_a <= idx_a + 1;
  always @(posedge ifb.pad_clk or posedge ifb.pad_latch)
    if (ifb.pad_latch) idx_b <= 0; else if (idx_b < 8) idx_b <= idx_b + 1;

  nes_pad_reader #(.CLK_DIV_BITS(CDB), .INVERT_DATA(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  nes_pad_reader #(.CLK_DIV_BITS(CDB), .INVERT_DATA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // Model: t = clk edges since the accepting edge (-1 when idle).
  int         t_m [2] = '{-1, -1};
  logic [7:0] eb  [2] = '{8'h00, 8'h00};

  function automatic int next_t(input int t, input logic req);
    if (t < 0 || t >= POLL) return req ? 0 : -1;
    return t + 1;
  endfunction

  function automatic logic [7:0] result_of(input int i);
    if (i == 0) return tie_a ? 8'h00 : mask_a;
    return mask_b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        t_m[i] <= -1;
        eb[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t_m[i] <= next_t(t_m[i], (i == 0) ? poll_a : poll_b);
        if (next_t(t_m[i], (i == 0) ? poll_a : poll_b) == POLL)
          eb[i] <= result_of(i);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic lat, input logic pclk, input logic bsy,
                     input logic vld, input logic [7:0] btn);
    int   t;
    logic el, ec, ebsy, ev;
    t    = t_m[i];
    el   = (t >= 0) && (t < P);
    ec   = !((t >= P) && (t < POLL) && (((t - P) / P) % 2 == 0));
    ebsy = (t >= 0) && (t < POLL);
    ev   = (t == POLL);
    check($sformatf("pad_latch[%0d]", i), {31'd0, lat},  {31'd0, el});
    check($sformatf("pad_clk[%0d]", i),   {31'd0, pclk}, {31'd0, ec});
    check($sformatf("busy[%0d]", i),      {31'd0, bsy},  {31'd0, ebsy});
    check($sformatf("valid[%0d]", i),     {31'd0, vld},  {31'd0, ev});
    check($sformatf("buttons[%0d]", i),   {24'd0, btn},  {24'd0, eb[i]});
  endtask

  always @(negedge clk) begin
    if (ifa.valid === 1'b1) va_cnt++;
    if (chk_en) begin
      cmp(0, ifa.pad_latch, ifa.pad_clk, ifa.busy, ifa.valid, ifa.buttons);
      cmp(1, ifb.pad_latch, ifb.pad_clk, ifb.busy, ifb.valid, ifb.buttons);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_latch"},   {31'd0, ifa.pad_latch}, 32'd0);
    check({tag, "_clk"},     {31'd0, ifa.pad_clk},   32'd1);
    check({tag, "_busy"},    {31'd0, ifa.busy},      32'd0);
    check({tag, "_valid"},   {31'd0, ifa.valid},     32'd0);
    check({tag, "_buttons"}, {24'd0, ifa.buttons},   32'd0);
  endtask

  // Single-pulse poll; k counts samples after the accepting edge.
  task automatic run_poll(input int i, output int lat, output int fal, output int bs,
                          output int vn, output int vk, output logic [7:0] vb);
    logic prev, l, c, b, v;
    logic [7:0] bt;
    lat = 0; fal = 0; bs = 0; vn = 0; vk = -1; vb = 8'hxx;
    @(negedge clk);
    if (i == 0) poll_a = 1'b1; else poll_b = 1'b1;
    prev = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      poll_a = 1'b0; poll_b = 1'b0;
      if (i == 0) begin l = ifa.pad_latch; c = ifa.pad_clk; b = ifa.busy; v = ifa.valid; bt = ifa.buttons; end
      else        begin l = ifb.pad_latch; c = ifb.pad_clk; b = ifb.busy; v = ifb.valid; bt = ifb.buttons; end
      if (l) lat++;
      if (prev && !c) fal++;
      prev = c;
      if (b) bs++;
      if (v) begin vn++; vk = k; vb = bt; end
    end
  endtask

  initial begin
    int lat, fal, bs, vn, vk, n, first, second, v0;
    logic [7:0] vb, b1, b2;

    // Reset asserted between edges.
    #2 rst = 1'b1;
    #1 check_reset_vals("reset_async");
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = va_cnt;
    repeat (100) @(negedge clk);
    check("no_valid_after_reset", va_cnt - v0, 0);

    // Pressed mask 5A, active-low pad.
    mask_a = 8'h5A;
    run_poll(0, lat, fal, bs, vn, vk, vb);
    check("latch_cycles", lat, 4);
    check("pad_clk_falls", fal, 8);
    check("busy_cycles", bs, 64);
    check("valid_count_5a", vn, 1);
    check("valid_edge", vk, 64);
    check("buttons_5a", {24'd0, vb}, 32'h5A);

    // No pad: data pulled high.
    tie_a = 1'b1;
    run_poll(0, lat, fal, bs, vn, vk, vb);
    check("valid_count_nopad", vn, 1);
    check("buttons_nopad", {24'd0, vb}, 32'h00);
    tie_a = 1'b0;

    // poll_req held high across two polls.
    mask_a = 8'hFF;
    n = 0; first = -1; second = -1; b1 = 8'h00; b2 = 8'h00;
    @(negedge clk);
    poll_a = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifa.valid) begin
        n++;
        if (n == 1) begin first = k; b1 = ifa.buttons; mask_a = 8'h81; end
        else if (n == 2) begin second = k; b2 = ifa.buttons; poll_a = 1'b0; end
      end
    end
    poll_a = 1'b0;
    check("held_valid_count", n, 2);
    check("held_spacing", second - first, 65);
    check("held_buttons_ff", {24'd0, b1}, 32'hFF);
    check("held_buttons_81", {24'd0, b2}, 32'h81);

    // Reset during READ_HI after bit 3 (samples 32..35).
    mask_a = 8'h3C;
    @(negedge clk);
    poll_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      poll_a = 1'b0;
    end
    check("mid_poll_clk_high", {31'd0, ifa.pad_clk}, 32'd1);
    check("mid_poll_busy", {31'd0, ifa.busy}, 32'd1);
    v0 = va_cnt;
    #2 rst = 1'b1;
    #1 check_reset_vals("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_valid_after_mid_reset", va_cnt - v0, 0);
    run_poll(0, lat, fal, bs, vn, vk, vb);
    check("valid_count_3c", vn, 1);
    check("buttons_3c", {24'd0, vb}, 32'h3C);

    // INVERT_DATA=0 reader, active-high pad.
    mask_b = 8'hA5;
    run_poll(1, lat, fal, bs, vn, vk, vb);
    check("valid_count_a5", vn, 1);
    check("valid_edge_a5", vk, 64);
    check("buttons_a5", {24'd0, vb}, 32'hA5);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
